sdram_pass_arbiter: RTL and testbench



---
 rtl/sdram_pass_arbiter.sv | 142 ++++++++++++++
 tb/tb_sdram_pass_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_pass_arbiter.sv
// Two-client round-robin arbiter in front of the single sdram pass engine.
// Latches one-cycle pass requests and holds each grant for a whole pass.
//
// state      | meaning
// -----------+----------------------------------------------------------
// INIT       | core still initialising, wait for m_done=1
// IDLE       | pick a pending client, register owner and direction
// ISSUE      | one-cycle m_start to the core, arm the launch timer
// WAIT_ACK   | wait for m_done to fall; timer expiry aborts the pass
// RUN        | pass in progress, route ready strobes to owner
// COMPLETE   | done pulse to owner, release its busy, update rr pointer
module sdram_pass_arbiter #(
  parameter int DW       = 16,
  parameter int START_TO = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          c0_start,
  input  logic          c0_rnw,
  input  logic [DW-1:0] c0_wdat,
  output logic          c0_busy,
  output logic          c0_done,
  output logic          c0_ready,
  output logic [DW-1:0] c0_rdat,
  input  logic          c1_start,
  input  logic          c1_rnw,
  input  logic [DW-1:0] c1_wdat,
  output logic          c1_busy,
  output logic          c1_done,
  output logic          c1_ready,
  output logic [DW-1:0] c1_rdat,
  output logic          m_start,
  output logic          m_rnw,
  output logic [DW-1:0] m_wdat,
  input  logic          m_done,
  input  logic          m_ready,
  input  logic [DW-1:0] m_rdat,
  output logic          owner,
  output logic          err
);

  localparam int CW = $clog2(START_TO + 1);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_ISSUE, S_WAIT_ACK, S_RUN, S_COMPLETE
  } state_t;

  state_t        state, state_nx;
  logic [1:0]    pend;
  logic [1:0]    rnw_q;
  logic [1:0]    start_in;
  logic [1:0]    rnw_in;
  logic          last;
  logic [CW-1:0] cnt;
  logic          grant_en;
  logic          grant_id;
  logic          tmo_hit;
  logic          route_ok;

  assign start_in = {c1_start, c0_start};
  assign rnw_in   = {c1_rnw, c0_rnw};

  always_comb begin
    state_nx = state;
    grant_en = 1'b0;
    grant_id = owner;
    tmo_hit  = 1'b0;
    case (state)
      S_INIT: if (m_done) state_nx = S_IDLE;
      S_IDLE: begin
        if (|pend) begin
          grant_en = 1'b1;
          grant_id = (pend == 2'b11) ? ~last : pend[1];
          state_nx = S_ISSUE;
        end
      end
      S_ISSUE: state_nx = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (!m_done) begin
          state_nx = S_RUN;
        end else if (cnt == '0) begin
          tmo_hit  = 1'b1;
          state_nx = S_COMPLETE;
        end
      end
      S_RUN:      if (m_done) state_nx = S_COMPLETE;
      S_COMPLETE: state_nx = S_IDLE;
      default:    state_nx = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_INIT;
      pend  <= 2'b00;
      rnw_q <= 2'b00;
      last  <= 1'b1;
      owner <= 1'b0;
      m_rnw <= 1'b1;
      err   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      // capture is gated by the current pending bit, so an owner start in
      // COMPLETE is dropped while the other client can still queue up
      for (int n = 0; n < 2; n++) begin
        if (start_in[n] && !pend[n]) begin
          pend[n]  <= 1'b1;
          rnw_q[n] <= rnw_in[n];
        end
      end
      if (state == S_COMPLETE) begin
        pend[owner] <= 1'b0;
        last        <= owner;
      end
      if (grant_en) begin
        owner <= grant_id;
        m_rnw <= rnw_q[grant_id];
      end
      if (state == S_ISSUE) begin
        cnt <= CW'(START_TO);
      end else if (state == S_WAIT_ACK && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      if (tmo_hit) err <= 1'b1;
    end
  end

  assign route_ok = (state == S_WAIT_ACK) || (state == S_RUN);

  assign m_start  = (state == S_ISSUE);
  assign c0_busy  = pend[0];
  assign c1_busy  = pend[1];
  assign c0_done  = (state == S_COMPLETE) && !owner;
  assign c1_done  = (state == S_COMPLETE) && owner;
  assign c0_ready = m_ready && route_ok && !owner;
  assign c1_ready = m_ready && route_ok && owner;
  assign m_wdat   = owner ? c1_wdat : c0_wdat;
  assign c0_rdat  = m_rdat;
  assign c1_rdat  = m_rdat;

endmodule

// File: tb/tb_sdram_pass_arbiter.sv
// Self-checking bench for sdram_pass_arbiter: behavioural core model,
// table of arbitration scenarios and a word scoreboard for routing.
module tb_sdram_pass_arbiter;

  localparam int DW       = 16;
  localparam int START_TO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          c0_start, c0_rnw, c1_start, c1_rnw;
  logic [DW-1:0] c0_wdat, c1_wdat, c0_rdat, c1_rdat;
  logic          c0_busy, c0_done, c0_ready, c1_busy, c1_done, c1_ready;
  logic          m_start, m_rnw, m_done, m_ready, owner, err;
  logic [DW-1:0] m_wdat, m_rdat;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic          own;
    logic [DW-1:0] rdat;
    logic [DW-1:0] wdat;
  } word_t;
  word_t sb[$];

  typedef struct {
    logic s0, s1, r0, r1;
    logic eo, er;
    logic inj, inj_rnw, own_cmp;
    int   nw;
  } vec_t;
  vec_t vecs[8];

  sdram_pass_arbiter #(.DW(DW), .START_TO(START_TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .c0_start(c0_start), .c0_rnw(c0_rnw), .c0_wdat(c0_wdat),
    .c0_busy(c0_busy), .c0_done(c0_done), .c0_ready(c0_ready), .c0_rdat(c0_rdat),
    .c1_start(c1_start), .c1_rnw(c1_rnw), .c1_wdat(c1_wdat),
    .c1_busy(c1_busy), .c1_done(c1_done), .c1_ready(c1_ready), .c1_rdat(c1_rdat),
    .m_start(m_start), .m_rnw(m_rnw), .m_wdat(m_wdat),
    .m_done(m_done), .m_ready(m_ready), .m_rdat(m_rdat),
    .owner(owner), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic done_of(input logic n);
    return n ? c1_done : c0_done;
  endfunction

  function automatic logic busy_of(input logic n);
    return n ? c1_busy : c0_busy;
  endfunction

  function automatic logic ready_of(input logic n);
    return n ? c1_ready : c0_ready;
  endfunction

  // Core model: waits for m_start, drops m_done 3 cycles later, issues nw
  // strobes, then raises m_done. With tmo it keeps m_done high throughout.
  task automatic run_pass(input logic eo, input logic er, input int nw, input int exp_wait,
                          input logic tmo, input logic inj, input logic inj_rnw,
                          input logic own_cmp);
    int n;
    word_t w;
    n = 0;
    while (!m_start && n < 40) begin
      tick();
      n++;
    end
    chk("m_start_seen", m_start, 1);
    if (exp_wait >= 0) chk("m_start_latency", n, exp_wait);
    chk("owner", owner, eo);
    chk("m_rnw", m_rnw, er);
    tick();
    chk("m_start_one_cycle", m_start, 0);
    if (tmo) begin
      n = 1;
      while (!done_of(eo) && n < 40) begin
        tick();
        n++;
      end
      chk("timeout_done_cycle", n, START_TO + 2);
      chk("err_set", err, 1);
      tick();
      chk("timeout_busy_clear", busy_of(eo), 0);
      return;
    end
    tick();
    tick();
    m_done = 1'b0;
    tick();
    for (int i = 0; i < nw; i++) begin
      m_ready = 1'b1;
      m_rdat  = DW'($urandom);
      c0_wdat = DW'($urandom);
      c1_wdat = DW'($urandom);
      w.own  = eo;
      w.rdat = m_rdat;
      w.wdat = eo ? c1_wdat : c0_wdat;
      sb.push_back(w);
      if (inj && i == 2) begin
        if (eo) begin c0_start = 1'b1; c0_rnw = inj_rnw; end
        else    begin c1_start = 1'b1; c1_rnw = inj_rnw; end
      end
      #1;
      chk("owner_ready", ready_of(eo), 1);
      chk("other_ready", ready_of(!eo), 0);
      if (ready_of(eo) && sb.size() > 0) begin
        w = sb.pop_front();
        chk("rdat", eo ? c1_rdat : c0_rdat, w.rdat);
        chk("m_wdat", m_wdat, w.wdat);
      end
      tick();
      m_ready  = 1'b0;
      c0_start = 1'b0;
      c1_start = 1'b0;
      #1;
      chk("gap_ready", {c1_ready, c0_ready}, 0);
      if (inj && i == 2) chk("inj_busy", busy_of(!eo), 1);
      tick();
    end
    m_done = 1'b1;
    #1;
    chk("done_early", done_of(eo), 0);
    tick();
    chk("done_pulse", done_of(eo), 1);
    chk("other_done", done_of(!eo), 0);
    if (own_cmp) begin
      if (eo) c1_start = 1'b1;
      else    c0_start = 1'b1;
    end
    tick();
    c0_start = 1'b0;
    c1_start = 1'b0;
    chk("done_once", done_of(eo), 0);
    chk("busy_clear", busy_of(eo), 0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; m_done = 1'b0; m_ready = 1'b0; m_rdat = '0;
    c0_start = 1'b0; c0_rnw = 1'b0; c0_wdat = '0;
    c1_start = 1'b0; c1_rnw = 1'b0; c1_wdat = '0;

    //                s0 s1 r0 r1 eo er inj irnw ocmp nw
    vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3};

    // reset and init: m_done low until cycle 20, c0 request at cycle 5
    tick(); tick();
    chk("rst_m_start", m_start, 0);
    chk("rst_m_rnw", m_rnw, 1);
    chk("rst_busy", {c1_busy, c0_busy}, 0);
    chk("rst_err", err, 0);
    chk("rst_owner", owner, 0);
    rst_n = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      tick();
      c0_start = (k == 5);
      c0_rnw   = 1'b0;
      m_done   = (k >= 20);
      m_ready  = (k == 10);
      #1;
      chk("init_no_m_start", m_start, 0);
      chk("init_busy", c0_busy, (k >= 6));
      if (k == 10) chk("init_ready_drop", {c1_ready, c0_ready}, 0);
    end
    c0_start = 1'b0;
    m_ready  = 1'b0;
    run_pass(1'b0, 1'b0, 8, 1, 1'b0, 1'b0, 1'b0, 1'b0);

    // fresh reset so the rr pointer starts at last=1
    rst_n = 1'b0;
    #1;
    chk("rst2_m_rnw", m_rnw, 1);
    chk("rst2_owner", owner, 0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 8; v++) begin
      if (vecs[v].s0 || vecs[v].s1) begin
        c0_start = vecs[v].s0; c0_rnw = vecs[v].r0;
        c1_start = vecs[v].s1; c1_rnw = vecs[v].r1;
        tick();
        c0_start = 1'b0;
        c1_start = 1'b0;
        if (vecs[v].s0) chk("vec_busy0", c0_busy, 1);
        if (vecs[v].s1) chk("vec_busy1", c1_busy, 1);
      end
      run_pass(vecs[v].eo, vecs[v].er, vecs[v].nw, 1, 1'b0,
               vecs[v].inj, vecs[v].inj_rnw, vecs[v].own_cmp);
    end

    // launch timeout, then a good pass with err staying set
    c0_start = 1'b1; c0_rnw = 1'b0;
    tick();
    c0_start = 1'b0;
    run_pass(1'b0, 1'b0, 0, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    c1_start = 1'b1; c1_rnw = 1'b1;
    tick();
    c1_start = 1'b0;
    run_pass(1'b1, 1'b1, 4, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("err_sticky", err, 1);

    // async reset mid-RUN with c1 pending
    c0_start = 1'b1; c0_rnw = 1'b0;
    tick();
    c0_start = 1'b0;
    n = 0;
    while (!m_start && n < 40) begin
      tick();
      n++;
    end
    chk("mid_m_start", m_start, 1);
    tick(); tick(); tick();
    m_done = 1'b0;
    tick(); tick();
    c1_start = 1'b1; c1_rnw = 1'b1;
    tick();
    c1_start = 1'b0;
    chk("mid_c1_busy", c1_busy, 1);
    m_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_m_start", m_start, 0);
    chk("mid_rst_m_rnw", m_rnw, 1);
    chk("mid_rst_busy", {c1_busy, c0_busy}, 0);
    chk("mid_rst_done", {c1_done, c0_done}, 0);
    chk("mid_rst_ready", {c1_ready, c0_ready}, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_owner", owner, 0);
    m_ready = 1'b0;
    m_done  = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("post_rst_m_start", m_start, 0);
      chk("post_rst_done", {c1_done, c0_done}, 0);
      chk("post_rst_busy", {c1_busy, c0_busy}, 0);
    end
    c1_start = 1'b1; c1_rnw = 1'b0;
    tick();
    c1_start = 1'b0;
    run_pass(1'b1, 1'b0, 3, 1, 1'b0, 1'b0, 1'b0, 1'b0);

    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
